// File: rtl/fifo_rd_stream_if.sv
// Bundle of the FIFO read port and the downstream valid/ready stream seen by fifo_rd_stream.
interface fifo_rd_stream_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1
);
    localparam int unsigned BUF_DEPTH = RD_LATENCY + 2;
    localparam int unsigned LVL_W     = $clog2(BUF_DEPTH + 1);

    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [LVL_W-1:0]      buf_level;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        output m_valid,
        input  m_ready,
        output m_data,
        output buf_level
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  buf_level
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-port drainer: credit-limited pops land in a small circular skid buffer
// whose head is presented as a valid/ready stream.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    fifo_rd_stream_if.master bus
);
    localparam int unsigned BUF_DEPTH = RD_LATENCY + 2;
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
    localparam int unsigned SUM_W     = CNT_W + 1;

    logic [RD_LATENCY-1:0] issue_q, issue_d;
    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_d [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [SUM_W-1:0]      inflight;
    logic                  rd_en;
    logic                  push;
    logic                  pop;

    // Credit: words in flight plus words buffered must leave room; a same-cycle pop is not credited.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight = inflight + SUM_W'(issue_q[i]);
        end
        rd_en = !rst && !bus.fifo_empty
                && ((inflight + SUM_W'(count_q)) < SUM_W'(BUF_DEPTH));
    end

    assign push = issue_q[RD_LATENCY-1];
    assign pop  = (count_q != '0) && bus.m_ready;

    always_comb begin
        issue_d    = '0;
        buf_d      = buf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        issue_d[0] = rd_en;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            issue_d[i] = issue_q[i-1];
        end
        if (push) begin
            buf_d[wr_ptr_q] = bus.fifo_rd_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Reset drops buffered words and in-flight issue bits so late read data is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            issue_q  <= issue_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            buf_q    <= buf_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (count_q != '0);
    assign bus.m_data     = buf_q[rd_ptr_q];
    assign bus.buf_level  = count_q;

`ifndef SYNTHESIS
    // The credit rule makes overflow unreachable; this guards against regressions.
    no_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == CNT_W'(BUF_DEPTH))));
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream across four width/latency configurations.
module tb_fifo_rd_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u[0]: 8b/L1, u[1]: 32b/L2, u[2]: 1b/L1, u[3]: 64b/L1; each with a FIFO model and monitor
    for (genvar g = 0; g < 4; g++) begin : u
        localparam int unsigned DW  = (g == 0) ? 8 : (g == 1) ? 32 : (g == 2) ? 1 : 64;
        localparam int unsigned LAT = (g == 1) ? 2 : 1;

        fifo_rd_stream_if #(.DATA_WIDTH(DW), .RD_LATENCY(LAT)) bus ();
        fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.master)
        );

        logic [63:0] mem [256];
        logic [63:0] dpipe [LAT];
        logic [63:0] rx [256];
        int          rx_t [256];
        int          wr_cnt = 0;
        int          rd_cnt = 0;
        int          rx_cnt = 0;
        int          rden_cnt = 0;
        int          empty_viol = 0;
        int          max_level = 0;
        logic        hold_empty = 1'b0;
        logic        m_ready = 1'b0;

        assign bus.fifo_empty   = hold_empty || (rd_cnt >= wr_cnt);
        assign bus.m_ready      = m_ready;
        assign bus.fifo_rd_data = DW'(dpipe[LAT-1]);

        always @(posedge clk) begin
            if (bus.fifo_rd_en === 1'b1) begin
                dpipe[0] <= mem[rd_cnt % 256];
                rd_cnt   <= rd_cnt + 1;
            end else begin
                dpipe[0] <= {4{16'hBEEF}} ^ 64'(cyc);
            end
            for (int k = 1; k < int'(LAT); k++) dpipe[k] <= dpipe[k-1];
        end

        always @(negedge clk) begin
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                rx[rx_cnt % 256]   <= 64'(bus.m_data);
                rx_t[rx_cnt % 256] <= cyc;
                rx_cnt             <= rx_cnt + 1;
            end
            if (bus.fifo_rd_en === 1'b1) rden_cnt <= rden_cnt + 1;
            if (bus.fifo_rd_en === 1'b1 && bus.fifo_empty === 1'b1) empty_viol <= empty_viol + 1;
            if (int'(bus.buf_level) > max_level) max_level <= int'(bus.buf_level);
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (u[0].bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid0: got %b want 0", u[0].bus.m_valid); end
        vectors++; if (u[0].bus.buf_level !== 2'd0) begin miscompares++; $display("FAIL reset_level0: got %0d want 0", u[0].bus.buf_level); end
        vectors++; if (u[0].bus.m_data !== 8'h00) begin miscompares++; $display("FAIL reset_data0: got %h want 00", u[0].bus.m_data); end
        vectors++; if (u[0].bus.fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rden0: got %b want 0", u[0].bus.fifo_rd_en); end
        vectors++; if (u[1].bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid1: got %b want 0", u[1].bus.m_valid); end
        vectors++; if (u[1].bus.buf_level !== 3'd0) begin miscompares++; $display("FAIL reset_level1: got %0d want 0", u[1].bus.buf_level); end
        vectors++; if (u[3].bus.m_data !== 64'h0) begin miscompares++; $display("FAIL reset_data3: got %h want 0", u[3].bus.m_data); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int s_rx, s_rd, t0;
        @(posedge clk); #1;
        u[0].m_ready = 1'b1;
        s_rx = u[0].rx_cnt; s_rd = u[0].rden_cnt; t0 = cyc;
        for (int i = 0; i < 30; i++) u[0].mem[(u[0].wr_cnt + i) % 256] = 64'(i);
        u[0].wr_cnt = u[0].wr_cnt + 30;
        for (int c = 0; c < 200 && u[0].rx_cnt < s_rx + 30; c++) begin @(posedge clk); #1; end
        vectors++; if (u[0].rx_cnt != s_rx + 30) begin miscompares++; $display("FAIL stream_count: got %0d want 30", u[0].rx_cnt - s_rx); end
        for (int i = 0; i < 30; i++) begin
            vectors++;
            if (u[0].rx[(s_rx + i) % 256] !== 64'(i)) begin miscompares++; $display("FAIL stream_word%0d: got %h want %h", i, u[0].rx[(s_rx + i) % 256], 64'(i)); end
        end
        vectors++; if (u[0].rx_t[s_rx % 256] - t0 != 2) begin miscompares++; $display("FAIL stream_latency: got %0d want 2", u[0].rx_t[s_rx % 256] - t0); end
        vectors++; if (u[0].rx_t[(s_rx + 29) % 256] - u[0].rx_t[s_rx % 256] != 29) begin miscompares++; $display("FAIL stream_rate: got %0d want 29", u[0].rx_t[(s_rx + 29) % 256] - u[0].rx_t[s_rx % 256]); end
        vectors++; if (u[0].rden_cnt - s_rd != 30) begin miscompares++; $display("FAIL stream_rden: got %0d want 30", u[0].rden_cnt - s_rd); end
    endtask

    task automatic test_backpressure();
        int s_rx, s_rd, bad;
        logic seen;
        bad = 0; seen = 1'b0;
        @(posedge clk); #1;
        u[0].m_ready = 1'b0;
        s_rx = u[0].rx_cnt; s_rd = u[0].rden_cnt;
        for (int i = 0; i < 16; i++) u[0].mem[(u[0].wr_cnt + i) % 256] = 64'(8'h40 + i);
        u[0].wr_cnt = u[0].wr_cnt + 16;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (u[0].bus.m_valid === 1'b1) begin
                seen = 1'b1;
                if (u[0].bus.m_data !== 8'h40) bad++;
            end
        end
        vectors++; if (u[0].rden_cnt - s_rd != 3) begin miscompares++; $display("FAIL bp_rden: got %0d want 3", u[0].rden_cnt - s_rd); end
        vectors++; if (u[0].bus.buf_level !== 2'd3) begin miscompares++; $display("FAIL bp_level: got %0d want 3", u[0].bus.buf_level); end
        vectors++; if (!seen || bad != 0) begin miscompares++; $display("FAIL bp_hold: seen %b unstable %0d want seen 1 unstable 0", seen, bad); end
        u[0].m_ready = 1'b1;
        for (int c = 0; c < 200 && u[0].rx_cnt < s_rx + 16; c++) begin @(posedge clk); #1; end
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (u[0].rx_cnt != s_rx + 16) begin miscompares++; $display("FAIL bp_count: got %0d want 16", u[0].rx_cnt - s_rx); end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (u[0].rx[(s_rx + i) % 256] !== 64'(8'h40 + i)) begin miscompares++; $display("FAIL bp_word%0d: got %h want %h", i, u[0].rx[(s_rx + i) % 256], 64'(8'h40 + i)); end
        end
    endtask

    task automatic test_empty_toggle();
        int s_rx, s_v;
        @(posedge clk); #1;
        s_rx = u[0].rx_cnt; s_v = u[0].empty_viol;
        u[0].hold_empty = 1'b1;
        for (int i = 0; i < 20; i++) u[0].mem[(u[0].wr_cnt + i) % 256] = 64'(i);
        u[0].wr_cnt = u[0].wr_cnt + 20;
        for (int c = 0; c < 300 && u[0].rx_cnt < s_rx + 20; c++) begin
            @(posedge clk); #1;
            u[0].hold_empty = ~u[0].hold_empty;
        end
        u[0].hold_empty = 1'b0;
        vectors++; if (u[0].empty_viol != s_v) begin miscompares++; $display("FAIL empty_rden: got %0d pops while empty want 0", u[0].empty_viol - s_v); end
        vectors++; if (u[0].rx_cnt != s_rx + 20) begin miscompares++; $display("FAIL empty_count: got %0d want 20", u[0].rx_cnt - s_rx); end
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (u[0].rx[(s_rx + i) % 256] !== 64'(i)) begin miscompares++; $display("FAIL empty_word%0d: got %h want %h", i, u[0].rx[(s_rx + i) % 256], 64'(i)); end
        end
    endtask

    task automatic test_wide_latency();
        int s_rx, t0;
        @(posedge clk); #1;
        u[1].m_ready = 1'b1;
        s_rx = u[1].rx_cnt; t0 = cyc;
        for (int i = 0; i < 30; i++) u[1].mem[(u[1].wr_cnt + i) % 256] = 64'({16'hDEAD, 16'(i)});
        u[1].wr_cnt = u[1].wr_cnt + 30;
        for (int c = 0; c < 200 && u[1].rx_cnt < s_rx + 30; c++) begin @(posedge clk); #1; end
        vectors++; if (u[1].rx_cnt != s_rx + 30) begin miscompares++; $display("FAIL lat2_count: got %0d want 30", u[1].rx_cnt - s_rx); end
        for (int i = 0; i < 30; i++) begin
            vectors++;
            if (u[1].rx[(s_rx + i) % 256] !== 64'({16'hDEAD, 16'(i)})) begin miscompares++; $display("FAIL lat2_word%0d: got %h want %h", i, u[1].rx[(s_rx + i) % 256], 64'({16'hDEAD, 16'(i)})); end
        end
        vectors++; if (u[1].rx_t[s_rx % 256] - t0 != 3) begin miscompares++; $display("FAIL lat2_latency: got %0d want 3", u[1].rx_t[s_rx % 256] - t0); end
        vectors++; if (u[1].rx_t[(s_rx + 29) % 256] - u[1].rx_t[s_rx % 256] != 29) begin miscompares++; $display("FAIL lat2_rate: got %0d want 29", u[1].rx_t[(s_rx + 29) % 256] - u[1].rx_t[s_rx % 256]); end
        vectors++; if (u[1].max_level > 4) begin miscompares++; $display("FAIL lat2_maxlevel: got %0d want <=4", u[1].max_level); end
    endtask

    task automatic test_reset_midflight();
        int s_rx, s_rd;
        @(posedge clk); #1;
        u[1].m_ready = 1'b0;
        s_rx = u[1].rx_cnt; s_rd = u[1].rden_cnt;
        for (int i = 0; i < 6; i++) u[1].mem[(u[1].wr_cnt + i) % 256] = 64'(32'h5A5A_0000 + i);
        u[1].wr_cnt = u[1].wr_cnt + 6;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (u[1].bus.buf_level !== 3'd1) begin miscompares++; $display("FAIL mid_prelevel: got %0d want 1", u[1].bus.buf_level); end
        rst = 1'b1;
        #1;
        vectors++; if (u[1].bus.fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL mid_rden_in_rst: got %b want 0", u[1].bus.fifo_rd_en); end
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (u[1].bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b want 0", u[1].bus.m_valid); end
        vectors++; if (u[1].bus.buf_level !== 3'd0) begin miscompares++; $display("FAIL mid_level: got %0d want 0", u[1].bus.buf_level); end
        u[1].m_ready = 1'b1;
        for (int c = 0; c < 100 && u[1].rx_cnt < s_rx + 3; c++) begin @(posedge clk); #1; end
        repeat (6) @(posedge clk);
        #1;
        vectors++; if (u[1].rx_cnt != s_rx + 3) begin miscompares++; $display("FAIL mid_count: got %0d want 3", u[1].rx_cnt - s_rx); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (u[1].rx[(s_rx + i) % 256] !== 64'(32'h5A5A_0003 + i)) begin miscompares++; $display("FAIL mid_word%0d: got %h want %h", i, u[1].rx[(s_rx + i) % 256], 64'(32'h5A5A_0003 + i)); end
        end
        vectors++; if (u[1].rden_cnt - s_rd != 6) begin miscompares++; $display("FAIL mid_rden: got %0d want 6", u[1].rden_cnt - s_rd); end
    endtask

    task automatic test_widths();
        int s2, s3;
        logic [63:0] pat [4];
        pat[0] = 64'hFFFF_FFFF_FFFF_FFFF; pat[1] = 64'h0;
        pat[2] = 64'hAAAA_AAAA_AAAA_AAAA; pat[3] = 64'h5555_5555_5555_5555;
        @(posedge clk); #1;
        s2 = u[2].rx_cnt; s3 = u[3].rx_cnt;
        for (int i = 0; i < 16; i++) u[2].mem[(u[2].wr_cnt + i) % 256] = 64'(i % 2);
        u[2].wr_cnt = u[2].wr_cnt + 16;
        for (int i = 0; i < 12; i++) u[3].mem[(u[3].wr_cnt + i) % 256] = pat[i % 4];
        u[3].wr_cnt = u[3].wr_cnt + 12;
        for (int c = 0; c < 600 && (u[2].rx_cnt < s2 + 16 || u[3].rx_cnt < s3 + 12); c++) begin
            u[2].m_ready = 1'($urandom_range(0, 1));
            u[3].m_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        u[2].m_ready = 1'b0; u[3].m_ready = 1'b0;
        vectors++; if (u[2].rx_cnt != s2 + 16) begin miscompares++; $display("FAIL w1_count: got %0d want 16", u[2].rx_cnt - s2); end
        vectors++; if (u[3].rx_cnt != s3 + 12) begin miscompares++; $display("FAIL w64_count: got %0d want 12", u[3].rx_cnt - s3); end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (u[2].rx[(s2 + i) % 256] !== 64'(i % 2)) begin miscompares++; $display("FAIL w1_word%0d: got %h want %h", i, u[2].rx[(s2 + i) % 256], 64'(i % 2)); end
        end
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (u[3].rx[(s3 + i) % 256] !== pat[i % 4]) begin miscompares++; $display("FAIL w64_word%0d: got %h want %h", i, u[3].rx[(s3 + i) % 256], pat[i % 4]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_toggle();
        test_wide_latency();
        test_reset_midflight();
        test_widths();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
